sap1_controller: RTL
====================

SAP1_CONTROLLER -- requirements
Module: sap1_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: `clk` rises to advance all state; `rst_n` is sampled on the `clk` rising edge and resets when low.
REQ-002 SHALL expose these ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `run`  in  1  step enable; state advances only when high
- `opcode`  in  4  instruction-register upper nibble
- `pc_inc`  out  1  program counter increment
- `pc_out`  out  1  program counter drives bus
- `mar_load`  out  1  memory address register loads from bus
- `ram_out`  out  1  RAM drives bus
- `ir_load`  out  1  instruction register loads from bus
- `ir_out`  out  1  instruction-register operand nibble drives bus
- `a_load`  out  1  accumulator loads
- `a_out`  out  1  accumulator drives bus
- `b_load`  out  1  B register loads
- `alu_sub`  out  1  drives the ALU subtract select
- `alu_out`  out  1  ALU result drives bus
- `out_load`  out  1  output register loads
- `halted`  out  1  halt reached
- `t_state`  out  3  current T-state, 1..6 (0 while halted)

Function
REQ-003 SHALL sequence a one-hot ring counter T1..T6; T6 wraps to T1; advances one step per `clk` edge with `run`=1.
REQ-004 SHALL decode control outputs combinationally from the current T-state and `opcode` (Moore-style); the target register loads on the edge that ends the T-state.
REQ-005 SHALL assert in the fetch states, for every opcode:
- T1: `pc_out`, `mar_load`
- T2: `pc_inc`
- T3: `ram_out`, `ir_load`
REQ-006 SHALL decode LDA=0000 as:
- T4: `ir_out`, `mar_load`
- T5: `ram_out`, `a_load`
- T6: no outputs
REQ-007 SHALL decode ADD=0001 as:
- T4: `ir_out`, `mar_load`
- T5: `ram_out`, `b_load`
- T6: `alu_out`, `a_load`, with `alu_sub`=0
REQ-008 SHALL decode SUB=0010 identically to ADD, except `alu_sub`=1 during T6 only.
REQ-009 SHALL decode OUT=1110 as: T4 `a_out`, `out_load`; T5 and T6 no outputs.
REQ-010 SHALL handle HLT=1111 at T4: enter HALT, assert `halted`=1 and `t_state`=0, drive all other outputs 0, and leave HALT only on reset.
REQ-011 SHALL treat every other opcode as NOP: no outputs in T4..T6.
REQ-012 SHALL, while `run`=0, hold the state and force all control outputs to 0; when `run` returns to 1, resume from the same T-state.
REQ-013 SHALL never assert more than one bus driver (`pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out`) in any cycle.

Reset
REQ-014 SHALL, while `rst_n`=0, force all control outputs and `halted` to 0; the edge that samples `rst_n`=0 loads state T1.
REQ-015 SHALL, on release with `run`=1, present T1 outputs in the first cycle.
REQ-016 SHALL, on reset asserted mid-instruction or in HALT, abandon the instruction and restart at T1.

Configuration
REQ-017 SHALL, with macro `SAP1_VAR_CYCLE_EN` defined, return to T1 directly after the last active T-state:
- LDA after T5
- OUT after T4
- NOP opcodes after T3
- ADD and SUB keep all six states
REQ-018 SHALL, without `SAP1_VAR_CYCLE_EN`, use a fixed six-state machine cycle for every instruction.

Structure
REQ-019 SHALL take the following from shared package `sap1_pkg`:
- opcode constants LDA, ADD, SUB, OUT, HLT
- T-state one-hot encoding type
- control-word bit-index constants
REQ-020 SHALL place the T-state register, wrap, hold and skip logic in sub-module `sap1_ring_counter`; decode stays in `sap1_controller`.

Verification
REQ-021 SHALL cover these directed scenarios (`run`=1 unless stated):
- Reset, then 3 cycles with `opcode`=0001 -> cycle 1 `pc_out`+`mar_load`, cycle 2 `pc_inc`, cycle 3 `ram_out`+`ir_load`; `t_state` reads 1,2,3.
- `opcode`=0010 through T4..T6 -> T6 has `alu_out`+`a_load`+`alu_sub`=1; `alu_sub`=0 in every other cycle.
- `opcode`=1111 -> `halted`=1 from T4, all outputs 0 for 20 cycles; `rst_n` low 1 cycle -> T1, `halted`=0.
- `run`=0 for 5 cycles during T5 of LDA -> outputs 0, `t_state`=5 held; `run`=1 -> `ram_out`+`a_load`.
- With `SAP1_VAR_CYCLE_EN`: `opcode`=1110 -> cycle after T4 is T1; `opcode`=0101 -> cycle after T3 is T1.
- Random opcodes for 1000 cycles -> at most one bus driver per cycle; `t_state` always in 1..6 or, once halted, 0.

Source files
------------

// File: rtl/sap1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap1_pkg
//  Purpose  : Shared opcodes, one-hot T-state type and control-word bit
//             indices for the SAP-1 controller slice.
//  Revision : 1.0  initial release
// ============================================================================
package sap1_pkg;

    // Instruction-register upper nibble encodings
    localparam logic [3:0] LDA = 4'b0000;
    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] OUT = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;

    // One-hot ring positions; all-zero is the terminal HALT state
    typedef enum logic [5:0] {
        TS_HALT = 6'b000000,
        TS_T1   = 6'b000001,
        TS_T2   = 6'b000010,
        TS_T3   = 6'b000100,
        TS_T4   = 6'b001000,
        TS_T5   = 6'b010000,
        TS_T6   = 6'b100000
    } tstate_t;

    // Control-word bit positions
    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_MAR_LOAD = 2;
    localparam int CW_RAM_OUT  = 3;
    localparam int CW_IR_LOAD  = 4;
    localparam int CW_IR_OUT   = 5;
    localparam int CW_A_LOAD   = 6;
    localparam int CW_A_OUT    = 7;
    localparam int CW_B_LOAD   = 8;
    localparam int CW_ALU_SUB  = 9;
    localparam int CW_ALU_OUT  = 10;
    localparam int CW_OUT_LOAD = 11;
    localparam int CW_WIDTH    = 12;

    // Binary step number of a ring position (0 for HALT)
    function automatic logic [2:0] tstate_num(input tstate_t s);
        logic [2:0] n;
        n = 3'd0;
        case (s)
            TS_T1:   n = 3'd1;
            TS_T2:   n = 3'd2;
            TS_T3:   n = 3'd3;
            TS_T4:   n = 3'd4;
            TS_T5:   n = 3'd5;
            TS_T6:   n = 3'd6;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Opcodes with no execute-phase activity
    function automatic logic is_nop(input logic [3:0] op);
        return !(op == LDA || op == ADD || op == SUB || op == OUT || op == HLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sap1_ring_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sap1_ring_counter
//  Purpose  : One-hot T1..T6 ring with run-hold, HLT capture and, when
//             SAP1_VAR_CYCLE_EN is defined, early return to T1 after the
//             last active step of short instructions.
//  Revision : 1.0  initial release
// ============================================================================
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    output tstate_t    state
);

    tstate_t r_state;
    logic    w_halt_req;
    logic    w_skip;

    assign w_halt_req = (r_state == TS_T4) && (opcode == HLT);

`ifdef SAP1_VAR_CYCLE_EN
    // Short instructions return to fetch right after their last useful step
    assign w_skip = ((r_state == TS_T5) && (opcode == LDA)) ||
                    ((r_state == TS_T4) && (opcode == OUT)) ||
                    ((r_state == TS_T3) && is_nop(opcode));
`else
    assign w_skip = 1'b0;
`endif

    // Advance the ring once per enabled edge; HALT is sticky until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= TS_T1;
        end else if (run) begin
            if (r_state == TS_HALT) begin
                r_state <= TS_HALT;
            end else if (w_halt_req) begin
                r_state <= TS_HALT;
            end else if (w_skip || r_state == TS_T6) begin
                r_state <= TS_T1;
            end else begin
                case (r_state)
                    TS_T1:   r_state <= TS_T2;
                    TS_T2:   r_state <= TS_T3;
                    TS_T3:   r_state <= TS_T4;
                    TS_T4:   r_state <= TS_T5;
                    TS_T5:   r_state <= TS_T6;
                    default: r_state <= TS_T1;
                endcase
            end
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/sap1_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sap1_controller
//  Purpose  : SAP-1 control sequencer. Decodes the control word from the
//             current T-state and opcode; the ring counter sub-module owns
//             sequencing. Optional macro SAP1_VAR_CYCLE_EN shortens LDA, OUT
//             and NOP machine cycles.
//  Revision : 1.0  initial release
// ============================================================================
module sap1_controller
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       pc_inc,
    output logic       pc_out,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_out,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] t_state
);

    tstate_t               w_state;
    logic [CW_WIDTH-1:0]   w_cw;
    logic                  w_halt;

    sap1_ring_counter u_ring (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .opcode (opcode),
        .state  (w_state)
    );

    // HLT is reported from the T4 it is decoded in, then held by the HALT state
    assign w_halt  = (w_state == TS_HALT) || ((w_state == TS_T4) && (opcode == HLT));
    assign halted  = rst_n && w_halt;
    assign t_state = w_halt ? 3'd0 : tstate_num(w_state);

    // Moore decode of the control word; silent in reset, pause and halt
    always_comb begin
        w_cw = '0;
        if (rst_n && run && !w_halt) begin
            case (w_state)
                TS_T1: begin
                    w_cw[CW_PC_OUT]   = 1'b1;
                    w_cw[CW_MAR_LOAD] = 1'b1;
                end
                TS_T2: begin
                    w_cw[CW_PC_INC]   = 1'b1;
                end
                TS_T3: begin
                    w_cw[CW_RAM_OUT]  = 1'b1;
                    w_cw[CW_IR_LOAD]  = 1'b1;
                end
                TS_T4: begin
                    case (opcode)
                        LDA, ADD, SUB: begin
                            w_cw[CW_IR_OUT]   = 1'b1;
                            w_cw[CW_MAR_LOAD] = 1'b1;
                        end
                        OUT: begin
                            w_cw[CW_A_OUT]    = 1'b1;
                            w_cw[CW_OUT_LOAD] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                TS_T5: begin
                    case (opcode)
                        LDA: begin
                            w_cw[CW_RAM_OUT] = 1'b1;
                            w_cw[CW_A_LOAD]  = 1'b1;
                        end
                        ADD, SUB: begin
                            w_cw[CW_RAM_OUT] = 1'b1;
                            w_cw[CW_B_LOAD]  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                TS_T6: begin
                    if (opcode == ADD || opcode == SUB) begin
                        w_cw[CW_ALU_OUT] = 1'b1;
                        w_cw[CW_A_LOAD]  = 1'b1;
                        w_cw[CW_ALU_SUB] = (opcode == SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_inc   = w_cw[CW_PC_INC];
    assign pc_out   = w_cw[CW_PC_OUT];
    assign mar_load = w_cw[CW_MAR_LOAD];
    assign ram_out  = w_cw[CW_RAM_OUT];
    assign ir_load  = w_cw[CW_IR_LOAD];
    assign ir_out   = w_cw[CW_IR_OUT];
    assign a_load   = w_cw[CW_A_LOAD];
    assign a_out    = w_cw[CW_A_OUT];
    assign b_load   = w_cw[CW_B_LOAD];
    assign alu_sub  = w_cw[CW_ALU_SUB];
    assign alu_out  = w_cw[CW_ALU_OUT];
    assign out_load = w_cw[CW_OUT_LOAD];

endmodule
`default_nettype wire
